// File: rtl/multicycle_core.sv
// multicycle_core: RV32I multi-cycle core on a single unified memory bus.
// Each instruction walks FETCH -> EXEC -> [MEM] -> WB; ebreak and traps park in HALT.
module multicycle_core #(
    parameter logic [31:0] RESET_VECTOR  = 32'h8000_0000,
    parameter int          COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_ready,
    output logic                     halted,
    output logic                     illegal,
    output logic [COUNTER_WIDTH-1:0] retire_count
);
    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;

    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [6:0]  OP_FENCE  = 7'b0001111;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    state_t      state, state_nxt;
    logic [31:0] pc, ir;
    logic [31:0] alu_q;    // ALU result; holds the effective address for loads/stores
    logic [31:0] load_q;   // extended load data waiting for write-back
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_val, rs2_val, imm, op_a, op_b, alu_res, pc_next, wb_data;
    logic [31:0] lane_data, load_ext, st_data;
    logic [3:0]  st_strb;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic        is_imm, is_reg, is_fence, is_ebreak, legal, taken, misaligned, reg_we;

    assign opcode  = ir[6:0];
    assign funct3  = ir[14:12];
    assign rd      = ir[11:7];
    assign rs1     = ir[19:15];
    assign rs2     = ir[24:20];
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign is_lui    = opcode == OP_LUI;
    assign is_auipc  = opcode == OP_AUIPC;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;
    assign is_branch = opcode == OP_BRANCH;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_imm    = opcode == OP_IMM;
    assign is_reg    = opcode == OP_REG;
    assign is_fence  = opcode == OP_FENCE;
    assign is_ebreak = ir == EBREAK;

    // funct3 holes in jalr/branch/load/store are treated as illegal too
    assign legal = is_lui | is_auipc | is_jal | is_imm | is_reg | is_fence
                 | (is_jalr && funct3 == 3'd0)
                 | (is_branch && funct3[2:1] != 2'b01)
                 | (is_load && funct3 != 3'd3 && funct3[2:1] != 2'b11)
                 | (is_store && !funct3[2] && funct3[1:0] != 2'b11);

    // Immediate generator: pick the format by opcode, I-type by default
    always_comb begin
        imm = {{20{ir[31]}}, ir[31:20]};
        if (is_store)               imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        else if (is_branch)         imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        else if (is_lui | is_auipc) imm = {ir[31:12], 12'd0};
        else if (is_jal)            imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    end

    // ALU: plain add covers lui/auipc/address generation, funct3 selects for op/op-imm
    always_comb begin
        op_a    = is_auipc ? pc : (is_lui ? 32'd0 : rs1_val);
        op_b    = is_reg ? rs2_val : imm;
        alu_res = op_a + op_b;
        if (is_reg | is_imm) begin
            case (funct3)
                3'd0: alu_res = (is_reg && ir[30]) ? op_a - op_b : op_a + op_b;
                3'd1: alu_res = op_a << op_b[4:0];
                3'd2: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
                3'd3: alu_res = {31'd0, op_a < op_b};
                3'd4: alu_res = op_a ^ op_b;
                3'd5: alu_res = ir[30] ? $unsigned($signed(op_a) >>> op_b[4:0]) : op_a >> op_b[4:0];
                3'd6: alu_res = op_a | op_b;
                default: alu_res = op_a & op_b;
            endcase
        end
    end

    // Branch comparator
    always_comb begin
        case (funct3)
            3'd0:    taken = rs1_val == rs2_val;
            3'd1:    taken = rs1_val != rs2_val;
            3'd4:    taken = $signed(rs1_val) < $signed(rs2_val);
            3'd5:    taken = $signed(rs1_val) >= $signed(rs2_val);
            3'd6:    taken = rs1_val < rs2_val;
            3'd7:    taken = rs1_val >= rs2_val;
            default: taken = 1'b0;
        endcase
    end

    // Registers are only written in WB, so operands read in WB still match EXEC
    assign pc_next = is_jalr ? ((rs1_val + imm) & ~32'd1)
                   : (is_jal | (is_branch & taken)) ? pc + imm : pc + 32'd4;
    assign reg_we  = !(is_branch | is_store | is_fence);
    assign wb_data = is_load ? load_q : (is_jal | is_jalr) ? pc + 32'd4 : alu_q;

    assign misaligned = (funct3[1:0] == 2'b01 && alu_q[0]) ||
                        (funct3[1:0] == 2'b10 && alu_q[1:0] != 2'b00);

    // Data splitter: store lane placement and load extraction/extension
    always_comb begin
        case (funct3[1:0])
            2'b00:   begin st_strb = 4'b0001 << alu_q[1:0]; st_data = {4{rs2_val[7:0]}};  end
            2'b01:   begin st_strb = 4'b0011 << alu_q[1:0]; st_data = {2{rs2_val[15:0]}}; end
            default: begin st_strb = 4'b1111;               st_data = rs2_val;            end
        endcase
        lane_data = mem_rdata >> {alu_q[1:0], 3'b000};
        case (funct3)
            3'd0:    load_ext = {{24{lane_data[7]}}, lane_data[7:0]};
            3'd1:    load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
            3'd4:    load_ext = {24'd0, lane_data[7:0]};
            3'd5:    load_ext = {16'd0, lane_data[15:0]};
            default: load_ext = lane_data;
        endcase
    end

    // FSM next state and bus outputs; reset kills the request combinationally
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) state_nxt = EXEC;
            end
            EXEC: begin
                if (is_ebreak || !legal)    state_nxt = HALT;
                else if (is_load | is_store) state_nxt = MEM;
                else                         state_nxt = WB;
            end
            MEM: begin
                if (misaligned) state_nxt = HALT;
                else begin
                    mem_req  = 1'b1;
                    mem_addr = {alu_q[31:2], 2'b00};
                    if (is_store) begin
                        mem_we    = 1'b1;
                        mem_wdata = st_data;
                        mem_wstrb = st_strb;
                    end
                    if (mem_ready) state_nxt = WB;
                end
            end
            WB:      state_nxt = FETCH;
            default: state_nxt = HALT;
        endcase
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_wstrb = 4'd0;
        end
    end

    // State register plus per-state datapath captures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_VECTOR;
            ir           <= 32'd0;
            alu_q        <= 32'd0;
            load_q       <= 32'd0;
            halted       <= 1'b0;
            illegal      <= 1'b0;
            retire_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                FETCH: if (mem_ready) ir <= mem_rdata;
                EXEC: begin
                    alu_q <= alu_res;
                    if (is_ebreak)   halted  <= 1'b1;
                    else if (!legal) illegal <= 1'b1;
                end
                MEM: begin
                    if (misaligned)                  illegal <= 1'b1;
                    else if (mem_ready && !is_store) load_q  <= load_ext;
                end
                WB: begin
                    pc           <= pc_next;
                    retire_count <= retire_count + COUNTER_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Register file write port; x0 is never written and reads as zero
    always_ff @(posedge clk) begin
        if (state == WB && reg_we && rd != 5'd0) regs[rd] <= wb_data;
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: dut_a (32-bit counter) and dut_b
// (4-bit counter) share one behavioural memory; only one runs at a time.
module tb_multicycle_core;
    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, ready_a, ready_b;
    logic        req_a, we_a, halted_a, illegal_a;
    logic        req_b, we_b, halted_b, illegal_b;
    logic [31:0] addr_a, wdata_a, rdata_a, addr_b, wdata_b, rdata_b;
    logic [3:0]  wstrb_a, wstrb_b;
    logic [31:0] rc_a;
    logic [3:0]  rc_b;
    logic [31:0] mem [1024];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    multicycle_core #(.RESET_VECTOR(RV), .COUNTER_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_wstrb(wstrb_a), .mem_rdata(rdata_a), .mem_ready(ready_a),
        .halted(halted_a), .illegal(illegal_a), .retire_count(rc_a));

    multicycle_core #(.RESET_VECTOR(RV), .COUNTER_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_wstrb(wstrb_b), .mem_rdata(rdata_b), .mem_ready(ready_b),
        .halted(halted_b), .illegal(illegal_b), .retire_count(rc_b));

    assign rdata_a = mem[addr_a[11:2]];
    assign rdata_b = mem[addr_b[11:2]];

    // Byte-strobed writes on completed store transfers
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (req_a && ready_a && we_a && wstrb_a[k]) mem[addr_a[11:2]][8*k +: 8] <= wdata_a[8*k +: 8];
            if (req_b && ready_b && we_b && wstrb_b[k]) mem[addr_b[11:2]][8*k +: 8] <= wdata_b[8*k +: 8];
        end
    end

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [6:0] op);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        #1;
        mem[0]  <= enc_i(12'd5,     5'd0, 3'd0, 5'd1, 7'h13);        // addi x1,x0,5
        mem[1]  <= enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd2, 7'h33);       // add  x2,x1,x1
        mem[2]  <= enc_s(12'h200, 5'd2, 5'd0, 3'd2, 7'h23);          // sw   x2,0x200(x0)
        mem[3]  <= enc_i(12'h102,   5'd0, 3'd0, 5'd1, 7'h13);        // addi x1,x0,0x102
        mem[4]  <= enc_i(12'h0AB,   5'd0, 3'd0, 5'd2, 7'h13);        // addi x2,x0,0xAB
        mem[5]  <= enc_s(12'h000, 5'd2, 5'd1, 3'd0, 7'h23);          // sb   x2,0(x1)
        mem[6]  <= enc_i(12'h000,   5'd1, 3'd4, 5'd3, 7'h03);        // lbu  x3,0(x1)
        mem[7]  <= enc_s(12'h204, 5'd3, 5'd0, 3'd2, 7'h23);          // sw   x3,0x204(x0)
        mem[8]  <= enc_i(12'h000,   5'd1, 3'd0, 5'd3, 7'h03);        // lb   x3,0(x1)
        mem[9]  <= enc_s(12'h208, 5'd3, 5'd0, 3'd2, 7'h23);          // sw   x3,0x208(x0)
        mem[10] <= enc_i(12'h000,   5'd1, 3'd2, 5'd4, 7'h03);        // lw   x4,0(x1) misaligned
        step(2);

        chk("rst_req",     {31'd0, req_a},     32'd0);
        chk("rst_retire",  rc_a,               32'd0);
        chk("rst_flags",   {30'd0, halted_a, illegal_a}, 32'd0);
        rst_a = 1'b0; #1;
        chk("first_req",   {31'd0, req_a},     32'd1);
        chk("first_addr",  addr_a,             RV);
        chk("first_we",    {31'd0, we_a},      32'd0);
        chk("first_wstrb", {28'd0, wstrb_a},   32'd0);

        step(5);
        chk("retire_5cyc", rc_a, 32'd1);
        step(1);
        chk("retire_6cyc", rc_a, 32'd2);

        // fetch of the sw stalls for three cycles
        ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req",  {31'd0, req_a}, 32'd1);
            chk("stall_addr", addr_a,         RV + 32'd8);
            step(1);
        end
        chk("stall_retire", rc_a, 32'd2);
        ready_a = 1'b1;
        step(3);
        chk("sw_not_yet", rc_a, 32'd2);
        step(1);
        chk("sw_retired", rc_a, 32'd3);
        chk("sw_x2",      mem[128], 32'd10);

        step(6);
        chk("addi_pair",  rc_a, 32'd5);
        step(2);
        chk("sb_req",     {31'd0, req_a},   32'd1);
        chk("sb_we",      {31'd0, we_a},    32'd1);
        chk("sb_addr",    addr_a,           32'h0000_0100);
        chk("sb_wstrb",   {28'd0, wstrb_a}, 32'h4);
        chk("sb_lane",    {24'd0, wdata_a[23:16]}, 32'hAB);
        step(2);
        chk("sb_retired", rc_a, 32'd6);
        step(16);
        chk("ld_retired", rc_a, 32'd10);
        chk("sb_mem",     mem[64],  32'h00AB_0000);
        chk("lbu_x3",     mem[129], 32'h0000_00AB);
        chk("lb_x3",      mem[130], 32'hFFFF_FFAB);

        step(2);
        chk("misal_noreq", {31'd0, req_a}, 32'd0);
        step(1);
        chk("misal_illegal", {31'd0, illegal_a}, 32'd1);
        chk("misal_halted",  {31'd0, halted_a},  32'd0);
        step(3);
        chk("misal_idle",    {31'd0, req_a}, 32'd0);
        chk("misal_retire",  rc_a, 32'd10);

        // 16 nops then beq x0,x0,-8 on the 4-bit counter core
        rst_a = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] <= enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13);
        mem[16] <= enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0, 7'h63);
        rst_b = 1'b0;
        step(45);
        chk("nop15", {28'd0, rc_b}, 32'd15);
        step(3);
        chk("nop_wrap",  {28'd0, rc_b}, 32'd0);
        chk("beq_fetch", addr_b, RV + 32'h40);
        step(3);
        chk("beq_target", addr_b, RV + 32'h38);
        chk("beq_retire", {28'd0, rc_b}, 32'd1);

        // asynchronous reset while a fetch is stalled
        ready_b = 1'b0;
        step(1);
        chk("b_stalled", {31'd0, req_b}, 32'd1);
        #2 rst_b = 1'b1;
        #1;
        chk("arst_req",    {31'd0, req_b},   32'd0);
        chk("arst_wstrb",  {28'd0, wstrb_b}, 32'd0);
        chk("arst_retire", {28'd0, rc_b},    32'd0);
        @(posedge clk); #1;
        rst_b = 1'b0; ready_b = 1'b1; #1;
        chk("arst_refetch", addr_b, RV);
        chk("arst_req2",    {31'd0, req_b}, 32'd1);

        // ebreak after one retired instruction
        rst_b = 1'b1;
        mem[0] <= enc_i(12'd1, 5'd0, 3'd0, 5'd5, 7'h13);             // addi x5,x0,1
        mem[1] <= 32'h0010_0073;                                     // ebreak
        rst_a = 1'b0;
        step(3);
        chk("pre_ebreak", rc_a, 32'd1);
        step(2);
        chk("ebreak_halted",  {31'd0, halted_a},  32'd1);
        chk("ebreak_illegal", {31'd0, illegal_a}, 32'd0);
        step(3);
        chk("halt_noreq",  {31'd0, req_a}, 32'd0);
        chk("halt_retire", rc_a, 32'd1);
        chk("halt_stays",  {31'd0, halted_a}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
